// File: rtl/round_timer_ctrl.sv
// Round sequencer and seconds timebase for the master game FSM.
// Counts round seconds from a prescaled clock, freezes on pause, stops on clear or deadline.
module round_timer_ctrl #(
    parameter int CLK_DIV     = 100000000,
    parameter int TIME_W      = 8,
    parameter int DEFAULT_SET = 10,
    parameter int DEFAULT_DDL = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [TIME_W-1:0] cfg_data,
    output logic [TIME_W-1:0] elapsed,
    output logic              tick_1s,
    output logic              time_eq_settime,
    output logic              time_ge_ddl,
    output logic              busy,
    output logic              cfg_err,
    output logic [1:0]        state_out
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_MAX   = PW'(CLK_DIV - 1);
    localparam logic [TIME_W-1:0] ELAPSED_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     presc, presc_nxt;
    logic [TIME_W-1:0] elapsed_nxt, elapsed_inc;
    logic [TIME_W-1:0] set_time, set_nxt;
    logic [TIME_W-1:0] deadline, ddl_nxt;
    logic              tick_nxt, err_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            presc    <= '0;
            elapsed  <= '0;
            set_time <= TIME_W'(DEFAULT_SET);
            deadline <= TIME_W'(DEFAULT_DDL);
            tick_1s  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            elapsed  <= elapsed_nxt;
            set_time <= set_nxt;
            deadline <= ddl_nxt;
            tick_1s  <= tick_nxt;
            cfg_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        elapsed_nxt = elapsed;
        tick_nxt    = 1'b0;
        elapsed_inc = (elapsed == ELAPSED_MAX) ? elapsed : elapsed + 1'b1;

        case (state)
            S_IDLE, S_DONE: begin
                // clear beats start, so a simultaneous pair leaves the state untouched
                if (start && !clear) begin
                    state_nxt   = S_RUN;
                    presc_nxt   = '0;
                    elapsed_nxt = '0;
                end
            end
            S_RUN: begin
                if (clear) begin
                    state_nxt = S_DONE;
                end else if (pause) begin
                    state_nxt = S_HOLD;
                end else if (presc == PRESC_MAX) begin
                    presc_nxt   = '0;
                    elapsed_nxt = elapsed_inc;
                    tick_nxt    = 1'b1;
                    if (elapsed_inc >= deadline) state_nxt = S_DONE;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            S_HOLD: begin
                // prescaler stays frozen so the partial second carries over on resume
                if (clear)       state_nxt = S_DONE;
                else if (!pause) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        set_nxt = set_time;
        ddl_nxt = deadline;
        err_nxt = 1'b0;
        if (cfg_we) begin
            if (busy) begin
                err_nxt = 1'b1;
            end else if (cfg_sel) begin
                // a zero deadline would end every round instantly
                if (cfg_data == '0) err_nxt = 1'b1;
                else                ddl_nxt = cfg_data;
            end else begin
                set_nxt = cfg_data;
            end
        end
    end

    assign busy            = (state == S_RUN) || (state == S_HOLD);
    assign time_eq_settime = busy && (elapsed == set_time);
    assign time_ge_ddl     = (state != S_IDLE) && (elapsed >= deadline);
    assign state_out       = state;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed self-checking bench for round_timer_ctrl with a 4-cycle second.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_round_timer_ctrl;

    localparam int CLK_DIV = 4;
    localparam int TIME_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, pause, clear;
    logic              cfg_we, cfg_sel;
    logic [TIME_W-1:0] cfg_data;
    logic [TIME_W-1:0] elapsed;
    logic              tick_1s, time_eq_settime, time_ge_ddl, busy, cfg_err;
    logic [1:0]        state_out;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    round_timer_ctrl #(
        .CLK_DIV(CLK_DIV), .TIME_W(TIME_W), .DEFAULT_SET(10), .DEFAULT_DDL(30)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .elapsed(elapsed), .tick_1s(tick_1s), .time_eq_settime(time_eq_settime),
        .time_ge_ddl(time_ge_ddl), .busy(busy), .cfg_err(cfg_err), .state_out(state_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int cnt);
        repeat (cnt) @(negedge clk);
    endtask

    task automatic wait_tick(input int budget, output int cnt);
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (!tick_1s && cnt < budget);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic cfg_write(input logic sel, input logic [TIME_W-1:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_data = data;
        cyc(1);
        cfg_we   = 1'b0;
    endtask

    // Full round from a fresh start: one tick every 4 cycles up to the deadline.
    task automatic run_round(input int set_v, input int ddl_v);
        int cnt;
        for (int k = 1; k <= ddl_v; k++) begin
            wait_tick(8, cnt);
            check("tick_period", cnt, 4);
            check("elapsed", elapsed, k);
            check("eq_settime", time_eq_settime, (k == set_v) ? 1 : 0);
            check("ge_ddl", time_ge_ddl, (k >= ddl_v) ? 1 : 0);
            check("state", state_out, (k >= ddl_v) ? 3 : 1);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0;
        cyc(2);
        check("rst_state", state_out, 0);
        check("rst_elapsed", elapsed, 0);
        check("rst_tick", tick_1s, 0);
        check("rst_err", cfg_err, 0);
        check("rst_busy", busy, 0);
        check("rst_eq", time_eq_settime, 0);
        check("rst_ge", time_ge_ddl, 0);
        reset = 1'b0;
        cyc(1);

        // 1: default round, tick every 4 cycles, eq at 10, DONE at 30
        pulse_start();
        check("t1_state", state_out, 1);
        check("t1_busy", busy, 1);
        check("t1_elapsed0", elapsed, 0);
        for (int k = 1; k <= 30; k++) begin
            for (int j = 0; j < 3; j++) begin
                cyc(1);
                check("t1_notick", tick_1s, 0);
                check("t1_eq_hold", time_eq_settime, (k - 1 == 10) ? 1 : 0);
            end
            cyc(1);
            check("t1_tick", tick_1s, 1);
            check("t1_elapsed", elapsed, k);
            check("t1_eq", time_eq_settime, (k == 10) ? 1 : 0);
            check("t1_ge", time_ge_ddl, (k >= 30) ? 1 : 0);
            check("t1_state_k", state_out, (k >= 30) ? 3 : 1);
        end
        cyc(1);
        check("t1_done_tick", tick_1s, 0);
        check("t1_done_elapsed", elapsed, 30);
        check("t1_done_ge", time_ge_ddl, 1);
        check("t1_done_busy", busy, 0);

        // 2: pause with prescaler at 2; resume ticks after 2 more edges
        pulse_start();
        check("t2_restart_elapsed", elapsed, 0);
        check("t2_restart_ge", time_ge_ddl, 0);
        cyc(2);
        pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            check("t2_hold_state", state_out, 2);
            check("t2_hold_tick", tick_1s, 0);
            check("t2_hold_elapsed", elapsed, 0);
        end
        pause = 1'b0;
        cyc(1);
        check("t2_resume_state", state_out, 1);
        check("t2_resume_tick0", tick_1s, 0);
        cyc(1);
        check("t2_resume_tick1", tick_1s, 0);
        cyc(1);
        check("t2_resume_tick2", tick_1s, 1);
        check("t2_resume_elapsed", elapsed, 1);

        // 3: clear at elapsed 12, then restart; clear also ends a HOLD
        for (int k = 2; k <= 12; k++) begin
            wait_tick(8, n);
            check("t3_period", n, 4);
        end
        check("t3_elapsed12", elapsed, 12);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        check("t3_state", state_out, 3);
        check("t3_elapsed", elapsed, 12);
        check("t3_tick", tick_1s, 0);
        check("t3_ge", time_ge_ddl, 0);
        check("t3_eq", time_eq_settime, 0);
        cyc(4);
        check("t3_hold_elapsed", elapsed, 12);
        check("t3_hold_state", state_out, 3);
        pulse_start();
        check("t3_restart_state", state_out, 1);
        check("t3_restart_elapsed", elapsed, 0);
        pause = 1'b1;
        cyc(1);
        check("t3_hold", state_out, 2);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        pause = 1'b0;
        check("t3_hold_clear", state_out, 3);

        // 4: configuration writes
        do_reset();
        cfg_write(1'b0, 8'd3);
        check("t4_set_err", cfg_err, 0);
        cfg_write(1'b1, 8'd5);
        check("t4_ddl_err", cfg_err, 0);
        cfg_write(1'b1, 8'd0);
        check("t4_ddl0_err", cfg_err, 1);
        cyc(1);
        check("t4_err_pulse", cfg_err, 0);
        pulse_start();
        check("t4_eq0", time_eq_settime, 0);
        cfg_write(1'b0, 8'd7);
        check("t4_run_err", cfg_err, 1);
        wait_tick(8, n);
        check("t4_first_period", n, 3);
        check("t4_err_clear", cfg_err, 0);
        check("t4_el1", elapsed, 1);
        wait_tick(8, n);
        check("t4_el2_eq", time_eq_settime, 0);
        wait_tick(8, n);
        check("t4_el3", elapsed, 3);
        check("t4_el3_eq", time_eq_settime, 1);
        wait_tick(8, n);
        check("t4_el4_eq", time_eq_settime, 0);
        check("t4_el4_state", state_out, 1);
        wait_tick(8, n);
        check("t4_el5", elapsed, 5);
        check("t4_done", state_out, 3);
        check("t4_ge", time_ge_ddl, 1);

        // 5: same-cycle events and reset mid-HOLD
        do_reset();
        start = 1'b1;
        clear = 1'b1;
        cyc(1);
        start = 1'b0;
        clear = 1'b0;
        check("t5_sc_state", state_out, 0);
        check("t5_sc_busy", busy, 0);
        pulse_start();
        cyc(3);
        check("t5_prewrap_tick", tick_1s, 0);
        pause = 1'b1;
        cyc(1);
        check("t5_wrap_state", state_out, 2);
        check("t5_wrap_tick", tick_1s, 0);
        check("t5_wrap_elapsed", elapsed, 0);
        cyc(2);
        check("t5_hold_tick", tick_1s, 0);
        #2 reset = 1'b1;
        #1;
        check("t5_async_state", state_out, 0);
        check("t5_async_elapsed", elapsed, 0);
        check("t5_async_busy", busy, 0);
        cyc(1);
        reset = 1'b0;
        pause = 1'b0;
        pulse_start();
        run_round(10, 30);

        // 6: saturation with deadline 255 and set-time 0
        do_reset();
        cfg_write(1'b1, 8'd255);
        check("t6_ddl_err", cfg_err, 0);
        cfg_write(1'b0, 8'd0);
        check("t6_set_err", cfg_err, 0);
        pulse_start();
        check("t6_eq_at0", time_eq_settime, 1);
        run_round(0, 255);
        cyc(8);
        check("t6_sat_elapsed", elapsed, 255);
        check("t6_sat_state", state_out, 3);
        check("t6_sat_tick", tick_1s, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
